alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer_pkg.sv | 52 +++++
 rtl/alu_seq_regfile.sv | 53 +++++
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared opcode, state and instruction-field definitions for
//               the ALU sequencer and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    localparam int DATA_W  = 32;
    localparam int INSTR_W = 16;
    localparam int REG_AW  = 2;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int RD_HI  = 12;
    localparam int RD_LO  = 11;
    localparam int RS_HI  = 10;
    localparam int RS_LO  = 9;
    localparam int RT_HI  = 8;
    localparam int RT_LO  = 7;
    localparam int IMM_HI = 6;
    localparam int IMM_LO = 0;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;
    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BLT = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } seq_state_e;

    function automatic logic op_writes_rd(input logic [2:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR});
    endfunction

    function automatic logic op_is_branch(input logic [2:0] op);
        return (op inside {OP_BEQ, OP_BLT});
    endfunction

    function automatic logic op_is_illegal(input logic [2:0] op);
        return !(op_writes_rd(op) || op_is_branch(op));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_regfile
// Description : 4x32 register file, one write port shared with the preload
//               path, two combinational read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              init_we_i,
    input  logic [REG_AW-1:0] init_addr_i,
    input  logic [DATA_W-1:0] init_data_i,
    input  logic [REG_AW-1:0] rd_addr_a_i,
    input  logic [REG_AW-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              w_we;
    logic [REG_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Writeback and preload are never active together (different FSM states).
    always_comb begin
        w_we   = wr_en_i | init_we_i;
        w_addr = wr_en_i ? wr_addr_i : init_addr_i;
        w_data = wr_en_i ? wr_data_i : init_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_we) begin
            regs_q[w_addr] <= w_data;
        end
    end

    assign rd_data_a_o = regs_q[rd_addr_a_i];
    assign rd_data_b_o = regs_q[rd_addr_b_i];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Four-state instruction sequencer driving an external ALU,
//               with register file writeback and relative branching.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int NREG = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               init_we,
    input  logic [REG_AW-1:0]  init_addr,
    input  logic [DATA_W-1:0]  init_data,
    output logic [DATA_W-1:0]  alu_ip_0,
    output logic [DATA_W-1:0]  alu_ip_1,
    output logic [2:0]         alu_opcode,
    input  logic [DATA_W-1:0]  alu_op_0,
    input  logic               alu_change_pc,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output logic               illegal
);

    seq_state_e         state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  result_q;
    logic               change_pc_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [DATA_W-1:0]  alu_ip_0_q;
    logic [DATA_W-1:0]  alu_ip_1_q;
    logic [2:0]         alu_opcode_q;
    logic               done_q;
    logic               illegal_q;

    logic [2:0]         w_opcode;
    logic [REG_AW-1:0]  w_rd;
    logic [REG_AW-1:0]  w_rs;
    logic [REG_AW-1:0]  w_rt;
    logic [6:0]         w_imm;
    logic [PC_W-1:0]    w_imm_pc;
    logic [DATA_W-1:0]  w_rs_data;
    logic [DATA_W-1:0]  w_rt_data;
    logic               w_rf_we;
    logic               w_init_we;

    assign w_opcode = instr_q[OPC_HI:OPC_LO];
    assign w_rd     = instr_q[RD_HI:RD_LO];
    assign w_rs     = instr_q[RS_HI:RS_LO];
    assign w_rt     = instr_q[RT_HI:RT_LO];
    assign w_imm    = instr_q[IMM_HI:IMM_LO];
    // Sign-extend (or truncate) the offset so the add wraps modulo 2^PC_W.
    assign w_imm_pc = PC_W'($signed(w_imm));

    assign w_rf_we   = (state_q == ST_WRITEBACK) && op_writes_rd(w_opcode);
    assign w_init_we = init_we && (state_q == ST_IDLE);

    alu_seq_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (w_rf_we),
        .wr_addr_i   (w_rd),
        .wr_data_i   (result_q),
        .init_we_i   (w_init_we),
        .init_addr_i (init_addr),
        .init_data_i (init_data),
        .rd_addr_a_i (w_rs),
        .rd_addr_b_i (w_rt),
        .rd_data_a_o (w_rs_data),
        .rd_data_b_o (w_rt_data)
    );

    always_comb begin
        pc_d = pc_q + PC_W'(1);
        if (op_is_branch(w_opcode) && change_pc_q) begin
            pc_d = pc_q + w_imm_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            instr_q      <= '0;
            result_q     <= '0;
            change_pc_q  <= 1'b0;
            pc_q         <= '0;
            alu_ip_0_q   <= '0;
            alu_ip_1_q   <= '0;
            alu_opcode_q <= 3'b000;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_ip_0_q   <= w_rs_data;
                    alu_ip_1_q   <= w_rt_data;
                    alu_opcode_q <= w_opcode;
                    state_q      <= op_is_illegal(w_opcode) ? ST_WRITEBACK : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    result_q    <= alu_op_0;
                    change_pc_q <= alu_change_pc;
                    state_q     <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    // Register write happens on this same edge via w_rf_we.
                    done_q    <= 1'b1;
                    illegal_q <= op_is_illegal(w_opcode);
                    pc_q      <= pc_d;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_ip_0    = alu_ip_0_q;
    assign alu_ip_1    = alu_ip_1_q;
    assign alu_opcode  = alu_opcode_q;
    assign pc          = pc_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer with a behavioural ALU and
//               an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int PC_W   = 8;
    localparam int PC_MOD = 1 << PC_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        init_we = 1'b0;
    logic [1:0]  init_addr = '0;
    logic [31:0] init_data = '0;
    logic [31:0] alu_ip_0, alu_ip_1, alu_op_0;
    logic [2:0]  alu_opcode;
    logic        alu_change_pc;
    logic [PC_W-1:0] pc;
    logic        done, illegal;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(PC_W), .NREG(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .init_we       (init_we),
        .init_addr     (init_addr),
        .init_data     (init_data),
        .alu_ip_0      (alu_ip_0),
        .alu_ip_1      (alu_ip_1),
        .alu_opcode    (alu_opcode),
        .alu_op_0      (alu_op_0),
        .alu_change_pc (alu_change_pc),
        .pc            (pc),
        .done          (done),
        .illegal       (illegal)
    );

    // Behavioural ALU attached to the sequencer.
    always_comb begin
        alu_op_0      = '0;
        alu_change_pc = 1'b0;
        case (alu_opcode)
            3'b100:  alu_op_0 = alu_ip_0 + alu_ip_1;
            3'b101:  alu_op_0 = alu_ip_0 - alu_ip_1;
            3'b110:  alu_op_0 = alu_ip_0 & alu_ip_1;
            3'b111:  alu_op_0 = alu_ip_0 | alu_ip_1;
            3'b010:  alu_change_pc = (alu_ip_0 == alu_ip_1);
            3'b011:  alu_change_pc = ($signed(alu_ip_0) < $signed(alu_ip_1));
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] ip0;
        logic [31:0] ip1;
        logic [2:0]  opc;
        int          pc;
        logic        ill;
        int          hs;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] m_reg [4];
    int          m_pc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_hs = 0;
    int          n_issued = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && instr_valid && instr_ready) n_hs <= n_hs + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt,
                                       input logic [6:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    // Instruction-level model: applies one instruction to the architectural state.
    function automatic exp_t model_exec(input logic [15:0] ins);
        exp_t e;
        logic [2:0] op = ins[15:13];
        int rd   = int'(ins[12:11]);
        int rs   = int'(ins[10:9]);
        int rt   = int'(ins[8:7]);
        int simm = int'($signed(ins[6:0]));
        int step = 1;
        e.ip0 = m_reg[rs];
        e.ip1 = m_reg[rt];
        e.opc = op;
        e.ill = (op == 3'd0) || (op == 3'd1);
        e.lat = e.ill ? 2 : 3;
        e.hs  = 0;
        case (op)
            3'd4: m_reg[rd] = e.ip0 + e.ip1;
            3'd5: m_reg[rd] = e.ip0 - e.ip1;
            3'd6: m_reg[rd] = e.ip0 & e.ip1;
            3'd7: m_reg[rd] = e.ip0 | e.ip1;
            3'd2: if (e.ip0 == e.ip1) step = simm;
            3'd3: if ($signed(e.ip0) < $signed(e.ip1)) step = simm;
            default: ;
        endcase
        m_pc = (m_pc + step + PC_MOD) % PC_MOD;
        e.pc = m_pc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no retirement (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("retire_pc", 32'(pc), 32'(mon_e.pc));
                    check("retire_illegal", 32'(illegal), 32'(mon_e.ill));
                    check("retire_ip0", alu_ip_0, mon_e.ip0);
                    check("retire_ip1", alu_ip_1, mon_e.ip1);
                    check("retire_opcode", 32'(alu_opcode), 32'(mon_e.opc));
                    check("retire_latency", 32'(cyc - mon_e.hs), 32'(mon_e.lat));
                end
            end else if (illegal) begin
                n_vec++;
                n_err++;
                $display("FAIL illegal_without_done: got illegal=1 expected 0 (t=%0t)", $time);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_pc = 0;
        sb.delete();
    endtask

    task automatic preload(input logic [1:0] a, input logic [31:0] d);
        instr_valid = 1'b0;
        init_we     = 1'b1;
        init_addr   = a;
        init_data   = d;
        if (instr_ready) m_reg[a] = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the sequencer is idle again.
    task automatic issue(input logic [15:0] ins, input bit keep, input bit pre,
                         input logic [1:0] pa, input logic [31:0] pd);
        exp_t e;
        int   guard = 0;
        instr       = ins;
        instr_valid = 1'b1;
        init_we     = pre;
        init_addr   = pa;
        init_data   = pd;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got instr_ready=0 expected 1 within 20 cycles");
            instr_valid = 1'b0;
            init_we     = 1'b0;
        end else begin
            if (pre) m_reg[pa] = pd;
            e    = model_exec(ins);
            e.hs = cyc + 1;
            sb.push_back(e);
            n_issued++;
            @(negedge clk);
            for (int k = 0; k < e.lat; k++) begin
                check("ready_busy", 32'(instr_ready), 32'd0);
                init_we   = 1'($urandom_range(0, 1));
                init_addr = 2'($urandom);
                init_data = $urandom;
                @(negedge clk);
            end
            init_we = 1'b0;
            check("ready_idle", 32'(instr_ready), 32'd1);
            if (!keep) instr_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ins;
        logic [31:0] d;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_ip0", alu_ip_0, 32'd0);
        check("reset_ip1", alu_ip_1, 32'd0);
        check("reset_opcode", 32'(alu_opcode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(instr_ready), 32'd1);

        // add r3 = r1 + r2, then an illegal op exposes r3 on operand 0
        preload(2'd1, 32'd2);
        preload(2'd2, 32'd3);
        issue(mk(3'b100, 2'd3, 2'd1, 2'd2, 7'd0), 0, 0, 2'd0, 32'd0);
        check("add_pc", 32'(pc), 32'd1);
        issue(mk(3'b001, 2'd3, 2'd3, 2'd0, 7'd0), 0, 0, 2'd0, 32'd0);
        check("add_r3", alu_ip_0, 32'd5);
        check("illegal_pc", 32'(pc), 32'd2);

        // and into r0, or into r1
        do_reset();
        preload(2'd1, 32'hF);
        preload(2'd2, 32'd3);
        issue(mk(3'b110, 2'd0, 2'd1, 2'd2, 7'd0), 0, 0, 2'd0, 32'd0);
        issue(mk(3'b111, 2'd1, 2'd1, 2'd2, 7'd0), 0, 0, 2'd0, 32'd0);
        check("andor_pc", 32'(pc), 32'd2);
        issue(mk(3'b000, 2'd0, 2'd0, 2'd1, 7'd0), 0, 0, 2'd0, 32'd0);
        check("andor_r0", alu_ip_0, 32'd3);
        check("andor_r1", alu_ip_1, 32'hF);

        // backward branch wraps below zero, then add wraps past 255
        do_reset();
        preload(2'd1, 32'd3);
        preload(2'd2, 32'd3);
        issue(mk(3'b010, 2'd0, 2'd1, 2'd2, 7'h7E), 0, 0, 2'd0, 32'd0);
        check("beq_taken_pc", 32'(pc), 32'd254);
        issue(mk(3'b011, 2'd0, 2'd1, 2'd2, 7'h7E), 0, 0, 2'd0, 32'd0);
        check("blt_nottaken_pc", 32'(pc), 32'd255);
        issue(mk(3'b100, 2'd0, 2'd1, 2'd2, 7'd0), 0, 0, 2'd0, 32'd0);
        check("add_wrap_pc", 32'(pc), 32'd0);

        // back-to-back with valid held high; first one also preloads r2 on the handshake
        issue(mk(3'b100, 2'd3, 2'd2, 2'd1, 7'd0), 1, 1, 2'd2, 32'd10);
        issue(mk(3'b101, 2'd0, 2'd3, 2'd2, 7'd0), 1, 0, 2'd0, 32'd0);
        issue(mk(3'b000, 2'd0, 2'd3, 2'd0, 7'd0), 0, 0, 2'd0, 32'd0);
        check("b2b_r3", alu_ip_0, 32'd13);
        check("b2b_r0", alu_ip_1, 32'd3);
        check("b2b_handshakes", 32'(n_hs), 32'(n_issued));

        // reset during EXECUTE aborts the add
        do_reset();
        preload(2'd1, 32'd2);
        preload(2'd2, 32'd3);
        instr       = mk(3'b100, 2'd3, 2'd1, 2'd2, 7'd0);
        instr_valid = 1'b1;
        n_issued++;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(instr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(instr_ready), 32'd1);
        issue(mk(3'b001, 2'd0, 2'd3, 2'd1, 7'd0), 0, 0, 2'd0, 32'd0);
        check("abort_r3", alu_ip_0, 32'd0);
        check("abort_r1", alu_ip_1, 32'd0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
                preload(2'($urandom), d);
            end
            ins = 16'($urandom);
            d   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 2'($urandom), d);
        end
        instr_valid = 1'b0;

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("handshake_count", 32'(n_hs), 32'(n_issued));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
